// File: rtl/demux_1x2_32bit_reg_if.sv
// Bus bundle for the registered 1-to-2 demux: one producer port and two
// consumer ports, each with valid/ready, plus per-port transfer counters.
interface demux_1x2_32bit_reg_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
);
  logic [WIDTH-1:0] in_data;
  logic             in_sel;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] out0_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out1_data;
  logic             out1_valid;
  logic             out1_ready;
  logic [CNT_W-1:0] out0_count;
  logic [CNT_W-1:0] out1_count;

  // Producer/consumer side (testbench or surrounding datapath)
  modport master (
    output in_data, in_sel, in_valid, out0_ready, out1_ready,
    input  in_ready, out0_data, out0_valid, out1_data, out1_valid,
           out0_count, out1_count
  );

  // Demux side
  modport slave (
    input  in_data, in_sel, in_valid, out0_ready, out1_ready,
    output in_ready, out0_data, out0_valid, out1_data, out1_valid,
           out0_count, out1_count
  );
endinterface

// File: rtl/demux_1x2_32bit_reg.sv
// Registered 1-to-2 demux. Each output port owns a one-entry holding slot
// with valid/ready, so a stalled consumer never blocks the other port.

// One output slot: EMPTY/FULL state, held word and wrapping drain counter.
module demux_1x2_slot #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] wdata,
  input  logic             ready,
  output logic [WIDTH-1:0] data,
  output logic             valid,
  output logic             drain,
  output logic [CNT_W-1:0] count
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_e;

  slot_state_e state_q, state_d;

  assign valid = (state_q == FULL);
  assign drain = valid & ready;

  // Slot state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Next state: a load always wins (refill during drain stays FULL)
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY: if (load) state_d = FULL;
      FULL: begin
        if (load)       state_d = FULL;
        else if (ready) state_d = EMPTY;
      end
      default: state_d = EMPTY;
    endcase
  end

  // Held word only changes on a load, so it is stable while stalled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)    data <= '0;
    else if (load) data <= wdata;
  end

  // Completed handshakes, wrapping naturally at 2^CNT_W
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     count <= '0;
    else if (drain) count <= count + 1'b1;
  end
endmodule

module demux_1x2_32bit_reg #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 16
) (
  input logic                  clk,
  input logic                  rst_n,
  demux_1x2_32bit_reg_if.slave bus
);
  localparam int NUM_PORTS = 2;

  logic [NUM_PORTS-1:0]            load, ready, valid, drain;
  logic [NUM_PORTS-1:0][WIDTH-1:0] data;
  logic [NUM_PORTS-1:0][CNT_W-1:0] count;
  logic                            accept;

  assign ready = {bus.out1_ready, bus.out0_ready};

  // Only the selected slot gates the input; it can take a word when empty
  // or when it is being drained in the same cycle.
  assign bus.in_ready = rst_n & (~valid[bus.in_sel] | drain[bus.in_sel]);
  assign accept       = bus.in_valid & bus.in_ready;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
    assign load[i] = accept & (bus.in_sel == 1'(i));

    demux_1x2_slot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .load  (load[i]),
      .wdata (bus.in_data),
      .ready (ready[i]),
      .data  (data[i]),
      .valid (valid[i]),
      .drain (drain[i]),
      .count (count[i])
    );
  end

  assign bus.out0_data  = data[0];
  assign bus.out0_valid = valid[0];
  assign bus.out0_count = count[0];
  assign bus.out1_data  = data[1];
  assign bus.out1_valid = valid[1];
  assign bus.out1_count = count[1];
endmodule

// File: tb/tb_demux_1x2_32bit_reg.sv
// Scoreboard bench for demux_1x2_32bit_reg: stimulus pushes expected words per
// port, a negedge monitor pops and compares on every completed output handshake.
module tb_demux_1x2_32bit_reg;
  logic clk = 1'b0;
  logic rst_n;

  demux_1x2_32bit_reg_if #(.WIDTH(32), .CNT_W(16)) bus ();

  demux_1x2_32bit_reg #(.WIDTH(32), .CNT_W(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] q0[$];
  logic [31:0] q1[$];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every completed output handshake must match the next queued word
  always @(negedge clk) begin
    if (bus.out0_valid && bus.out0_ready) begin
      if (q0.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL port0 unexpected word: got %0h expected none", bus.out0_data);
      end else chk("port0 data", 64'(bus.out0_data), 64'(q0.pop_front()));
    end
    if (bus.out1_valid && bus.out1_ready) begin
      if (q1.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL port1 unexpected word: got %0h expected none", bus.out1_data);
      end else chk("port1 data", 64'(bus.out1_data), 64'(q1.pop_front()));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Present a word, record its expected destination, hold until accepted.
  // Leaves in_valid high so back-to-back sends stream without a gap.
  task automatic send(input logic [31:0] d, input logic s);
    int waits = 0;
    bus.in_data = d; bus.in_sel = s; bus.in_valid = 1'b1;
    if (s) q1.push_back(d); else q0.push_back(d);
    @(negedge clk);
    while (!bus.in_ready && waits < 20) begin
      waits++;
      @(negedge clk);
    end
    if (!bus.in_ready) begin
      n_checks++; n_fail++;
      $display("FAIL send timeout: in_ready stuck 0 for data %0h", d);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0;
    bus.in_data = '0; bus.in_sel = 1'b0; bus.in_valid = 1'b0;
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    #1;
    // Reset state
    chk("rst out0_valid", 64'(bus.out0_valid), 64'd0);
    chk("rst out1_valid", 64'(bus.out1_valid), 64'd0);
    chk("rst out0_data",  64'(bus.out0_data),  64'd0);
    chk("rst out1_data",  64'(bus.out1_data),  64'd0);
    chk("rst counts",     64'({bus.out0_count, bus.out1_count}), 64'd0);
    chk("rst in_ready",   64'(bus.in_ready),   64'd0);
    tick(); tick();
    rst_n = 1'b1; #1;
    chk("post-rst in_ready sel0", 64'(bus.in_ready), 64'd1);
    bus.in_sel = 1'b1; #1;
    chk("post-rst in_ready sel1", 64'(bus.in_ready), 64'd1);

    // Basic routing
    send(32'h0F0F0F0F, 1'b0); bus.in_valid = 1'b0;
    chk("route0 out0_valid", 64'(bus.out0_valid), 64'd1);
    chk("route0 out0_data",  64'(bus.out0_data),  64'h0F0F0F0F);
    chk("route0 out1_valid", 64'(bus.out1_valid), 64'd0);
    tick();
    chk("route0 drained",    64'(bus.out0_valid), 64'd0);
    chk("route0 count0",     64'(bus.out0_count), 64'd1);
    send(32'hF0F0F0F0, 1'b1); bus.in_valid = 1'b0;
    chk("route1 out1_valid", 64'(bus.out1_valid), 64'd1);
    chk("route1 out1_data",  64'(bus.out1_data),  64'hF0F0F0F0);
    chk("route1 out0_valid", 64'(bus.out0_valid), 64'd0);
    tick();
    chk("route1 count1",     64'(bus.out1_count), 64'd1);
    chk("route1 count0",     64'(bus.out0_count), 64'd1);

    // Backpressure on port 0
    bus.out0_ready = 1'b0;
    send(32'h0F0F0F0F, 1'b0); bus.in_valid = 1'b0;
    chk("bp out0_valid", 64'(bus.out0_valid), 64'd1);
    bus.in_sel = 1'b0; #1;
    chk("bp in_ready sel0", 64'(bus.in_ready), 64'd0);
    bus.in_data = 32'hF0F0F0F0; bus.in_sel = 1'b1; bus.in_valid = 1'b1;
    q1.push_back(32'hF0F0F0F0); #1;
    chk("bp in_ready sel1", 64'(bus.in_ready), 64'd1);
    tick();
    chk("bp out1_valid", 64'(bus.out1_valid), 64'd1);
    chk("bp out0 stable", 64'(bus.out0_data), 64'h0F0F0F0F);
    bus.in_data = 32'hA5A5A5A5; bus.in_sel = 1'b0;
    q0.push_back(32'hA5A5A5A5); #1;
    chk("bp held off", 64'(bus.in_ready), 64'd0);
    tick();
    chk("bp out0 still held", 64'(bus.out0_data), 64'h0F0F0F0F);
    chk("bp out0 still valid", 64'(bus.out0_valid), 64'd1);
    bus.out0_ready = 1'b1; #1;
    chk("bp release in_ready", 64'(bus.in_ready), 64'd1);
    tick();
    bus.in_valid = 1'b0;
    chk("bp refill data",  64'(bus.out0_data),  64'hA5A5A5A5);
    chk("bp refill valid", 64'(bus.out0_valid), 64'd1);
    chk("bp count0 same-cycle", 64'(bus.out0_count), 64'd2);
    tick();
    chk("bp count0 final", 64'(bus.out0_count), 64'd3);
    chk("bp count1 final", 64'(bus.out1_count), 64'd2);
    chk("bp out0 empty",   64'(bus.out0_valid), 64'd0);

    // Streaming: 8 back-to-back words, alternating select
    for (int i = 0; i < 8; i++) begin
      bus.in_data = 32'h10000000 + 32'(i); bus.in_sel = i[0]; bus.in_valid = 1'b1;
      if (i[0]) q1.push_back(32'h10000000 + 32'(i)); else q0.push_back(32'h10000000 + 32'(i));
      #1;
      chk("stream in_ready", 64'(bus.in_ready), 64'd1);
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("stream count0", 64'(bus.out0_count), 64'd7);
    chk("stream count1", 64'(bus.out1_count), 64'd6);

    // Mid-operation reset with both ports full
    bus.out0_ready = 1'b0; bus.out1_ready = 1'b0;
    send(32'hDEAD0000, 1'b0);
    send(32'hBEEF0001, 1'b1); bus.in_valid = 1'b0;
    chk("mid full0", 64'(bus.out0_valid), 64'd1);
    chk("mid full1", 64'(bus.out1_valid), 64'd1);
    #1 rst_n = 1'b0;
    q0.delete(); q1.delete();
    bus.out0_ready = 1'b1; bus.out1_ready = 1'b1;
    #1;
    chk("mid rst valids", 64'({bus.out0_valid, bus.out1_valid}), 64'd0);
    chk("mid rst counts", 64'({bus.out0_count, bus.out1_count}), 64'd0);
    chk("mid rst in_ready", 64'(bus.in_ready), 64'd0);
    chk("mid rst data0", 64'(bus.out0_data), 64'd0);
    #1 rst_n = 1'b1;
    tick(); tick();
    chk("mid after valids", 64'({bus.out0_valid, bus.out1_valid}), 64'd0);
    chk("mid after counts", 64'({bus.out0_count, bus.out1_count}), 64'd0);

    // Counter wrap on port 1
    for (int i = 0; i < 65535; i++) begin
      bus.in_data = 32'(i); bus.in_sel = 1'b1; bus.in_valid = 1'b1;
      q1.push_back(32'(i));
      tick();
    end
    bus.in_valid = 1'b0;
    tick();
    chk("wrap count1 max", 64'(bus.out1_count), 64'hFFFF);
    send(32'hCAFEF00D, 1'b1); bus.in_valid = 1'b0;
    tick();
    chk("wrap count1 zero", 64'(bus.out1_count), 64'd0);
    chk("wrap count0 same", 64'(bus.out0_count), 64'd0);

    tick();
    chk("scoreboard q0 empty", 64'(q0.size()), 64'd0);
    chk("scoreboard q1 empty", 64'(q1.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/demux_1x2_32bit_reg.md
# demux_1x2_32bit_reg

Registered 1-to-2 demultiplexer for 32-bit datapath words: the inverse of the 32-bit 2-to-1 select mux. It steers each accepted input word to one of two output ports according to a select bit. Each output has a one-entry holding register with a valid/ready handshake, so either consumer can stall without corrupting the other path. It is used in the 32-bit MIPS datapath wherever one producer (ALU/result bus) must feed one of two consumers, e.g. register-file write port vs. memory store path.

## Interface
- WIDTH, 32, data word width
- CNT_W, 16, width of per-output transfer counters
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_data  input  WIDTH  word to route
- in_sel  input  1  destination: 0 = port 0, 1 = port 1
- in_valid  input  1  in_data/in_sel valid this cycle
- in_ready  output  1  block accepts the input this cycle
- out0_data  output  WIDTH  port 0 holding register
- out0_valid  output  1  port 0 holds a word
- out0_ready  input  1  port 0 consumer takes the word
- out1_data  output  WIDTH  port 1 holding register
- out1_valid  output  1  port 1 holds a word
- out1_ready  input  1  port 1 consumer takes the word
- out0_count  output  CNT_W  completed port 0 handshakes, wraps
- out1_count  output  CNT_W  completed port 1 handshakes, wraps

## Operation
- Per port n, a slot register (outn_data, outn_valid). Port state: EMPTY (valid=0) or FULL (valid=1).
- Input accept: acc = in_valid & in_ready. Drain n: dn = outn_valid & outn_ready.
- in_ready = rst_n & (~outS_valid | dS), where S = in_sel. Combinational from in_sel and outS_ready; not dependent on the unselected port.
- On acc with in_sel=n: outn_data <= in_data, outn_valid <= 1 (EMPTY->FULL, or FULL->FULL when dn in the same cycle).
- On dn without an accept to port n: outn_valid <= 0 (FULL->EMPTY); outn_data holds its last value.
- Unselected port is never written; its data and valid are unaffected by in_sel/in_valid.
- While outn_valid=1 and outn_ready=0, outn_data must remain stable.
- outn_ready while outn_valid=0 has no effect.
- Counters: outn_count increments by 1 on every dn; 2^CNT_W-1 wraps to 0. Simultaneous drains on both ports increment both counters.
- in_sel and in_data are ignored when in_valid=0.

## Timing
- Reset (rst_n low, asynchronous): out0/out1_data = 0, out0/out1_valid = 0, out0/out1_count = 0, in_ready = 0 (combinationally, while rst_n is low).
- First cycle after release: both ports EMPTY, in_ready = 1 for either select.
- Latency: word accepted at edge k appears on outn_data with outn_valid=1 after edge k (visible in cycle k+1).
- Throughput: one word per cycle per port when the consumer holds ready=1 (simultaneous drain and refill).
- Port FULL and not draining: in_ready=0 for that select; an input to the other port is still accepted the same cycle.
- Reset asserted mid-transfer: held words are discarded, counters cleared, no handshake completes in that cycle.

## Test plan
- Reset: assert rst_n=0 with out*_ready=1 -> all outputs 0, in_ready=0; release -> in_ready=1.
- Basic routing: in_data=32'h0F0F0F0F, in_sel=0, in_valid=1 for one cycle, out0_ready=1 -> out0_data=32'h0F0F0F0F, out0_valid=1 for one cycle, out0_count=1, out1_valid stays 0; repeat with 32'hF0F0F0F0, in_sel=1 -> appears on port 1 only, out1_count=1.
- Backpressure: out0_ready=0, send 32'h0F0F0F0F to port 0 -> out0_valid=1 and in_ready=0 for sel=0; a second word to sel=0 is held off; 32'hF0F0F0F0 to sel=1 is accepted; raise out0_ready -> port 0 drains and the pending word is accepted the same cycle.
- Streaming: 8 back-to-back words alternating sel, both ready=1 -> in_ready stays 1, each port shows its 4 words in order, counters = 4 each.
- Counter wrap: preload via 65536 port 1 transfers -> out1_count returns to 0; out0_count unchanged.
- Mid-operation reset: both ports FULL, pulse rst_n low between edges -> valids and counters 0 immediately, no stale word appears after release.
